// File: rtl/window_7x7_gen.sv
// rtl/window_7x7_gen.sv - streaming 7x7 neighbourhood generator with six internal line buffers
// Emits all 49 samples of each fully in-image window one cycle after its completing pixel.
module window_7x7_gen #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic [DATA_W-1:0] window [48:0],
    output logic              window_valid,
    output logic [11:0]       win_row,
    output logic [11:0]       win_col
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [11:0]       r_col_cnt;
    logic [11:0]       r_row_cnt;
    logic [DATA_W-1:0] r_lb  [6][IMG_W];
    logic [DATA_W-1:0] r_win [48:0];
    logic              r_valid;
    logic [11:0]       r_win_row;
    logic [11:0]       r_win_col;

    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_colv [7];
    logic              w_col_last;
    logic              w_row_last;
    logic              w_complete;

    assign w_addr     = r_col_cnt[AW-1:0];
    assign w_col_last = (r_col_cnt == 12'(IMG_W - 1));
    assign w_row_last = (r_row_cnt == 12'(IMG_H - 1));
    assign w_complete = (r_row_cnt >= 12'd6) && (r_col_cnt >= 12'd6);

    // Column entering the window: oldest row (lb5) on top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < 6; r++) begin
            w_colv[r] = r_lb[5-r][w_addr];
        end
        w_colv[6] = pix_in;
    end

    // Line buffers are never reset; stale rows are masked by the row>=6 qualifier.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb[0][w_addr] <= pix_in;
            for (int k = 1; k < 6; k++) begin
                r_lb[k][w_addr] <= r_lb[k-1][w_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_valid   <= 1'b0;
            r_win_row <= '0;
            r_win_col <= '0;
            for (int i = 0; i < 49; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_valid <= pix_valid && w_complete;
            if (pix_valid) begin
                for (int r = 0; r < 7; r++) begin
                    for (int c = 0; c < 6; c++) begin
                        r_win[r*7+c] <= r_win[r*7+c+1];
                    end
                    r_win[r*7+6] <= w_colv[r];
                end
                if (w_complete) begin
                    r_win_row <= r_row_cnt - 12'd3;
                    r_win_col <= r_col_cnt - 12'd3;
                end
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_last ? 12'd0 : r_row_cnt + 12'd1;
                end else begin
                    r_col_cnt <= r_col_cnt + 12'd1;
                end
            end
        end
    end

    assign window       = r_win;
    assign window_valid = r_valid;
    assign win_row      = r_win_row;
    assign win_col      = r_win_col;

endmodule

// File: tb/tb_window_7x7_gen.sv
// tb/tb_window_7x7_gen.sv - directed self-checking bench for window_7x7_gen
// Small 10x8 image, pixel value = row*16+col (+ frame base).
module tb_window_7x7_gen;

    localparam int W = 10;
    localparam int H = 8;

    typedef logic [49*32-1:0] flat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [31:0] pix_in = '0;
    logic [31:0] window [48:0];
    logic        window_valid;
    logic [11:0] win_row;
    logic [11:0] win_col;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    flat_t       cap_win[$];
    logic [11:0] cap_row[$];
    logic [11:0] cap_col[$];
    int          cap_cyc[$];
    flat_t       mon_f;

    window_7x7_gen #(.DATA_W(32), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .window       (window),
        .window_valid (window_valid),
        .win_row      (win_row),
        .win_col      (win_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (window_valid) begin
            for (int i = 0; i < 49; i++) mon_f[i*32 +: 32] = window[i];
            cap_win.push_back(mon_f);
            cap_row.push_back(win_row);
            cap_col.push_back(win_col);
            cap_cyc.push_back(cyc);
        end
    end

    function automatic flat_t exp_win(input int base, input int cr, input int cc);
        flat_t f;
        for (int i = 0; i < 49; i++)
            f[i*32 +: 32] = 32'(base + (cr - 3 + i / 7) * 16 + (cc - 3 + i % 7));
        return f;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_in    = d;
    endtask

    task automatic send_frame(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                drive(1'b1, 32'(base + r * 16 + c));
    endtask

    task automatic flush();
        repeat (3) drive(1'b0, 32'h0);
    endtask

    task automatic clear_caps();
        cap_win.delete();
        cap_row.delete();
        cap_col.delete();
        cap_cyc.delete();
    endtask

    task automatic test_reset();
        int nz;
        #1 rst = 1'b1;
        #20;
        nz = 0;
        for (int i = 0; i < 49; i++) if (window[i] !== 32'h0) nz++;
        checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL por_valid got %b exp 0", window_valid); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL por_window nonzero entries %0d exp 0", nz); end
        checks++; if (win_row !== 12'd0 || win_col !== 12'd0) begin errors++; $display("FAIL por_pos got %0d,%0d exp 0,0", win_row, win_col); end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 70; i++) drive(1'b1, 32'((i / W) * 16 + i % W));
        drive(1'b0, 32'h0);
        #2;
        checks++; if (window_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", window_valid); end
        rst = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < 49; i++) if (window[i] !== 32'h0) nz++;
        checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", window_valid); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL async_window nonzero entries %0d exp 0", nz); end
        checks++; if (win_row !== 12'd0 || win_col !== 12'd0) begin errors++; $display("FAIL async_pos got %0d,%0d exp 0,0", win_row, win_col); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        nz = 0;
        for (int i = 0; i < 49; i++) if (window[i] !== 32'h0) nz++;
        checks++; if (window_valid !== 1'b0 || nz !== 0) begin errors++; $display("FAIL reset_hold valid %b nonzero %0d exp 0 0", window_valid, nz); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_continuous();
        clear_caps();
        send_frame(0);
        flush();
        checks++; if (cap_win.size() !== 8) begin errors++; $display("FAIL cont_count got %0d exp 8", cap_win.size()); end
        checks++; if (cap_win[0][0*32 +: 32] !== 32'h00) begin errors++; $display("FAIL cont_w0 got %h exp 00", cap_win[0][0 +: 32]); end
        checks++; if (cap_win[0][24*32 +: 32] !== 32'h33) begin errors++; $display("FAIL cont_w24 got %h exp 33", cap_win[0][24*32 +: 32]); end
        checks++; if (cap_win[0][48*32 +: 32] !== 32'h66) begin errors++; $display("FAIL cont_w48 got %h exp 66", cap_win[0][48*32 +: 32]); end
        checks++; if (cap_row[0] !== 12'd3 || cap_col[0] !== 12'd3) begin errors++; $display("FAIL cont_pos got %0d,%0d exp 3,3", cap_row[0], cap_col[0]); end
        checks++; if (cap_win[7][48*32 +: 32] !== 32'h79) begin errors++; $display("FAIL cont_last_w48 got %h exp 79", cap_win[7][48*32 +: 32]); end
        for (int k = 0; k < 8 && k < cap_win.size(); k++) begin
            checks++;
            if (cap_win[k] !== exp_win(0, 3 + k / 4, 3 + k % 4) || cap_row[k] !== 12'(3 + k / 4) || cap_col[k] !== 12'(3 + k % 4)) begin
                errors++; $display("FAIL cont_win%0d got w24 %h pos %0d,%0d exp w24 %h pos %0d,%0d", k, cap_win[k][24*32 +: 32], cap_row[k], cap_col[k], 32'((k / 4) * 16 + k % 4 + 8'h33), 3 + k / 4, 3 + k % 4);
            end
        end
        for (int k = 1; k < 4 && k < cap_cyc.size(); k++) begin
            checks++; if (cap_cyc[k] - cap_cyc[k-1] !== 1) begin errors++; $display("FAIL cont_strobe_gap%0d got %0d exp 1", k, cap_cyc[k] - cap_cyc[k-1]); end
        end
    endtask

    task automatic test_row_boundary();
        checks++; if (cap_cyc[4] - cap_cyc[3] !== 7) begin errors++; $display("FAIL rowb_gap got %0d exp 7", cap_cyc[4] - cap_cyc[3]); end
        checks++; if (cap_win[4][0*32 +: 32] !== 32'h10) begin errors++; $display("FAIL rowb_w0 got %h exp 10", cap_win[4][0 +: 32]); end
        checks++; if (cap_win[4][6*32 +: 32] !== 32'h16) begin errors++; $display("FAIL rowb_w6 got %h exp 16", cap_win[4][6*32 +: 32]); end
        checks++; if (cap_win[4][42*32 +: 32] !== 32'h70) begin errors++; $display("FAIL rowb_w42 got %h exp 70", cap_win[4][42*32 +: 32]); end
        checks++; if (cap_row[4] !== 12'd4 || cap_col[4] !== 12'd3) begin errors++; $display("FAIL rowb_pos got %0d,%0d exp 4,3", cap_row[4], cap_col[4]); end
    endtask

    task automatic test_gaps();
        logic [31:0] s0, s24;
        logic [11:0] sr, sc;
        clear_caps();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(0, 99) < 40 || c == 7) begin
                    drive(1'b0, $urandom);
                    @(negedge clk);
                    s0 = window[0]; s24 = window[24]; sr = win_row; sc = win_col;
                    @(negedge clk);
                    checks++;
                    if (window[0] !== s0 || window[24] !== s24 || win_row !== sr || win_col !== sc) begin
                        errors++; $display("FAIL gap_hold r%0d c%0d got w24 %h exp %h", r, c, window[24], s24);
                    end
                    checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL gap_valid r%0d c%0d got %b exp 0", r, c, window_valid); end
                end
                drive(1'b1, 32'(r * 16 + c));
            end
        end
        flush();
        checks++; if (cap_win.size() !== 8) begin errors++; $display("FAIL gap_count got %0d exp 8", cap_win.size()); end
        for (int k = 0; k < 8 && k < cap_win.size(); k++) begin
            checks++;
            if (cap_win[k] !== exp_win(0, 3 + k / 4, 3 + k % 4) || cap_row[k] !== 12'(3 + k / 4) || cap_col[k] !== 12'(3 + k % 4)) begin
                errors++; $display("FAIL gap_win%0d got w24 %h pos %0d,%0d", k, cap_win[k][24*32 +: 32], cap_row[k], cap_col[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        send_frame(0);
        send_frame(32'h100);
        flush();
        checks++; if (cap_win.size() !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", cap_win.size()); end
        checks++; if (cap_cyc[8] - cap_cyc[7] !== 67) begin errors++; $display("FAIL b2b_gap got %0d exp 67", cap_cyc[8] - cap_cyc[7]); end
        checks++; if (cap_win[8][0 +: 32] !== 32'h100) begin errors++; $display("FAIL b2b_w0 got %h exp 100", cap_win[8][0 +: 32]); end
        checks++; if (cap_win[8][48*32 +: 32] !== 32'h166) begin errors++; $display("FAIL b2b_w48 got %h exp 166", cap_win[8][48*32 +: 32]); end
        for (int k = 8; k < 16 && k < cap_win.size(); k++) begin
            checks++;
            if (cap_win[k] !== exp_win(32'h100, 3 + (k - 8) / 4, 3 + (k - 8) % 4)) begin
                errors++; $display("FAIL b2b_win%0d got w0 %h w24 %h", k, cap_win[k][0 +: 32], cap_win[k][24*32 +: 32]);
            end
        end
    endtask

    task automatic test_reset_restart();
        for (int i = 0; i < 35; i++) drive(1'b1, 32'(32'h200 + (i / W) * 16 + i % W));
        @(posedge clk); #1;
        pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_caps();
        send_frame(0);
        flush();
        checks++; if (cap_win.size() !== 8) begin errors++; $display("FAIL rst35_count got %0d exp 8", cap_win.size()); end
        checks++; if (cap_win[0][0 +: 32] !== 32'h00) begin errors++; $display("FAIL rst35_w0 got %h exp 00", cap_win[0][0 +: 32]); end
        for (int k = 0; k < 8 && k < cap_win.size(); k++) begin
            checks++;
            if (cap_win[k] !== exp_win(0, 3 + k / 4, 3 + k % 4) || cap_row[k] !== 12'(3 + k / 4) || cap_col[k] !== 12'(3 + k % 4)) begin
                errors++; $display("FAIL rst35_win%0d got w24 %h pos %0d,%0d", k, cap_win[k][24*32 +: 32], cap_row[k], cap_col[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_row_boundary();
        test_gaps();
        test_back_to_back();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
